// File: rtl/measure_pkg.sv
// Shared constants and types for the measurement display block.
package measure_pkg;

  localparam int unsigned NUM_W      = 14;
  localparam int unsigned BCD_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W      = 4;

  // Counter value on the final double-dabble step
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(NUM_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [2:0] MODE_X    = 3'd1;
  localparam logic [2:0] MODE_Y    = 3'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Double-dabble correction applied to one BCD nibble before a shift
  function automatic logic [3:0] bcd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex value to active-low seven-segment glyph, bit order {g,f,e,d,c,b,a}.
module seg7_decode (
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);

  // Glyph lookup; 10..15 render as A b C d E F
  always_comb begin
    o_seg = 7'h7F;
    case (i_val)
      4'd0:    o_seg = 7'h40;
      4'd1:    o_seg = 7'h79;
      4'd2:    o_seg = 7'h24;
      4'd3:    o_seg = 7'h30;
      4'd4:    o_seg = 7'h19;
      4'd5:    o_seg = 7'h12;
      4'd6:    o_seg = 7'h02;
      4'd7:    o_seg = 7'h78;
      4'd8:    o_seg = 7'h00;
      4'd9:    o_seg = 7'h10;
      4'd10:   o_seg = 7'h08;
      4'd11:   o_seg = 7'h03;
      4'd12:   o_seg = 7'h46;
      4'd13:   o_seg = 7'h21;
      4'd14:   o_seg = 7'h06;
      default: o_seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/measure_display.sv
// Converts a 14-bit cursor measurement to five decimal seven-segment digits
// plus a mode/wave indicator, using a serial double-dabble conversion.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros on hex4..hex1.
module measure_display
  import measure_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic [NUM_W-1:0] num,
  input  logic [2:0]       measurement,
  input  logic [1:0]       waveSel,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex4,
  output logic [6:0]       hex5,
  output logic             busy,
  output logic             valid
);

  state_e           r_state;
  logic [NUM_W-1:0] r_num;      // latched value, doubles as the snapshot
  logic [2:0]       r_mode;
  logic [1:0]       r_wave;
  logic             r_snap_ok;  // snapshot holds a completed conversion
  logic [NUM_W-1:0] r_shreg;
  logic [BCD_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_acc_next;
  logic             w_change;
  logic [6:0]       w_seg [BCD_DIGITS];
  logic [6:0]       w_hex [BCD_DIGITS];
  logic [6:0]       w_ind_seg;
  logic [3:0]       w_ind_val;
  logic [6:0]       w_hex5;

  assign w_change = !r_snap_ok || (num != r_num) || (measurement != r_mode) ||
                    (waveSel != r_wave);

  // Nibble-wise add-3 correction ahead of the shift
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      w_adj[4*i +: 4] = bcd_adjust(r_acc[4*i +: 4]);
    end
  end

  // Top nibble never reaches 8 for a 14-bit input, so dropping its MSB is safe
  assign w_acc_next = (w_adj << 1) | {{(BCD_W-1){1'b0}}, r_shreg[NUM_W-1]};

  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
    seg7_decode u_dec (
      .i_val (r_acc[4*gi +: 4]),
      .o_seg (w_seg[gi])
    );
  end

  // Indicator: letter A..D for cursor x, digit 1..4 for cursor y
  assign w_ind_val = (r_mode == MODE_X) ? (4'd10 + {2'b00, r_wave}) : (4'd1 + {2'b00, r_wave});

  seg7_decode u_ind (
    .i_val (w_ind_val),
    .o_seg (w_ind_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [BCD_DIGITS-1:0] w_lead_zero;  // bit i: digits i..top are all zero

  // Running zero detect from the most significant digit downwards
  always_comb begin
    w_lead_zero = '0;
    w_lead_zero[BCD_DIGITS-1] = (r_acc[BCD_W-1 -: 4] == 4'd0);
    for (int i = int'(BCD_DIGITS) - 2; i >= 0; i--) begin
      w_lead_zero[i] = w_lead_zero[i+1] && (r_acc[4*i +: 4] == 4'd0);
    end
  end
`endif

  // Select the glyph for each display from the mode and converted digits
  always_comb begin
    for (int i = 0; i < BCD_DIGITS; i++) begin
      w_hex[i] = SEG_BLANK;
      if (r_mode == MODE_NONE) begin
        w_hex[i] = SEG_BLANK;
      end else if (r_mode > MODE_Y) begin
        w_hex[i] = SEG_DASH;
      end else begin
        w_hex[i] = w_seg[i];
`ifdef LEADING_ZERO_BLANK_EN
        if ((i != 0) && w_lead_zero[i]) w_hex[i] = SEG_BLANK;
`endif
      end
    end
    if (r_mode == MODE_NONE) begin
      w_hex5 = SEG_BLANK;
    end else if (r_mode > MODE_Y) begin
      w_hex5 = SEG_DASH;
    end else begin
      w_hex5 = w_ind_seg;
    end
  end

  // Conversion FSM with registered displays and status
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_num     <= '0;
      r_mode    <= '0;
      r_wave    <= '0;
      r_snap_ok <= 1'b0;
      r_shreg   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      hex0      <= SEG_BLANK;
      hex1      <= SEG_BLANK;
      hex2      <= SEG_BLANK;
      hex3      <= SEG_BLANK;
      hex4      <= SEG_BLANK;
      hex5      <= SEG_BLANK;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_change) begin
            r_num     <= num;
            r_mode    <= measurement;
            r_wave    <= waveSel;
            r_snap_ok <= 1'b0;
            r_shreg   <= num;
            r_acc     <= '0;
            r_cnt     <= '0;
            busy      <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc   <= w_acc_next;
          r_shreg <= r_shreg << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == SHIFT_LAST) r_state <= DONE;
        end
        DONE: begin
          hex0      <= w_hex[0];
          hex1      <= w_hex[1];
          hex2      <= w_hex[2];
          hex3      <= w_hex[3];
          hex4      <= w_hex[4];
          hex5      <= w_hex5;
          r_snap_ok <= 1'b1;
          valid     <= 1'b1;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_measure_display.sv
// Randomized self-checking bench for measure_display against a decimal
// arithmetic reference model. Honours LEADING_ZERO_BLANK_EN when defined.
module tb_measure_display;

  logic        clock;
  logic        resetn;
  logic [13:0] num;
  logic [2:0]  measurement;
  logic [1:0]  waveSel;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy;
  logic        valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         p10 [5] = '{1, 10, 100, 1000, 10000};
  logic [6:0] exp_disp [6];

  measure_display dut (
    .clock       (clock),
    .resetn      (resetn),
    .num         (num),
    .measurement (measurement),
    .waveSel     (waveSel),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5),
    .busy        (busy),
    .valid       (valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [6:0] e [6]);
    logic [6:0] g [6];
    g = '{hex0, hex1, hex2, hex3, hex4, hex5};
    for (int i = 0; i < 6; i++) check_eq($sformatf("%s_hex%0d", tag, i), 32'(g[i]), 32'(e[i]));
  endtask

  // Expected glyph for display idx from the decimal value, mode and wave
  function automatic logic [6:0] model_seg(input int idx, input int n, input int m, input int w);
    if (m == 0) return 7'h7F;
    if (m > 2) return 7'h3F;
    if (idx == 5) return (m == 1) ? glyph_tab[10 + w] : glyph_tab[w + 1];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && n < p10[idx]) return 7'h7F;
`endif
    return glyph_tab[(n / p10[idx]) % 10];
  endfunction

  task automatic drive(input int n, input int m, input int w);
    num         = n[13:0];
    measurement = m[2:0];
    waveSel     = w[1:0];
  endtask

  task automatic set_blank_disp();
    for (int i = 0; i < 6; i++) exp_disp[i] = 7'h7F;
  endtask

  // Called #1 after the edge on which the new inputs were launched
  task automatic conv_window(input int n, input int m, input int w, input int chg_at,
                             input int chg_num);
    logic [6:0] nxt [6];
    for (int i = 0; i < 6; i++) nxt[i] = model_seg(i, n, m, w);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock);
      #1;
      if (k < 16) begin
        check_eq($sformatf("busy_k%0d_n%0d", k, n), 32'(busy), 32'd1);
        if (k == 15) check_hex($sformatf("hold_n%0d", n), exp_disp);
      end else begin
        check_eq($sformatf("busy_done_n%0d", n), 32'(busy), 32'd0);
        check_eq($sformatf("valid_done_n%0d", n), 32'(valid), 32'd1);
        check_hex($sformatf("conv_n%0d_m%0d_w%0d", n, m, w), nxt);
      end
      if (k == chg_at) num = chg_num[13:0];
    end
    exp_disp = nxt;
  endtask

  int dn [7] = '{0, 9, 10000, 99, 99, 1000, 16382};
  int dm [7] = '{2, 1, 2, 0, 5, 1, 2};
  int dw [7] = '{0, 3, 3, 1, 2, 2, 1};

  initial begin
    int n, m, w, r;
    int last_n, last_m, last_w;

    resetn = 1'b0;
    drive(16383, 1, 0);
    set_blank_disp();
    repeat (3) @(posedge clock);
    #1;
    check_hex("reset", exp_disp);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_valid", 32'(valid), 32'd0);

    // First IDLE cycle after reset converts unconditionally
    resetn = 1'b1;
    conv_window(16383, 1, 0, 0, 0);

    for (int i = 0; i < 7; i++) begin
      drive(dn[i], dm[i], dw[i]);
      conv_window(dn[i], dm[i], dw[i], 0, 0);
    end

    // Input change mid-SHIFT is deferred to the next IDLE cycle
    drive(1234, 1, 1);
    conv_window(1234, 1, 1, 6, 56);
    conv_window(56, 1, 1, 0, 0);
    @(posedge clock);
    #1;
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Reset during SHIFT aborts and clears the displays immediately
    drive(4321, 2, 2);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock);
      #1;
      check_eq($sformatf("pre_rst_busy_k%0d", k), 32'(busy), 32'd1);
    end
    resetn = 1'b0;
    #1;
    set_blank_disp();
    check_hex("midrst", exp_disp);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_valid", 32'(valid), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    conv_window(4321, 2, 2, 0, 0);

    last_n = 4321;
    last_m = 2;
    last_w = 2;
    repeat (24) begin
      n = int'($urandom_range(0, 16383));
      r = int'($urandom_range(0, 9));
      if (r < 4) m = 1;
      else if (r < 8) m = 2;
      else if (r == 8) m = 0;
      else m = int'($urandom_range(3, 7));
      w = int'($urandom_range(0, 3));
      if (n == last_n && m == last_m && w == last_w) n = (n + 1) % 16384;
      drive(n, m, w);
      conv_window(n, m, w, 0, 0);
      last_n = n;
      last_m = m;
      last_w = w;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
